// File: rtl/a_pw_entry_if.sv
// Keypad/password handshake bundle between the keypad front end and a_main.
// The slave modport is the a_pw_entry side; the master is the keypad/a_main side.
interface a_pw_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        gen_rst;
  logic        lock_out;
  logic [15:0] pw_16bit;
  logic        enough;
  logic [2:0]  digit_count;
  logic        key_accept;
  logic        entry_timeout;

  modport master (
    output key_valid, key_code, gen_rst, lock_out,
    input  pw_16bit, enough, digit_count, key_accept, entry_timeout
  );

  modport slave (
    input  key_valid, key_code, gen_rst, lock_out,
    output pw_16bit, enough, digit_count, key_accept, entry_timeout
  );
endinterface

// File: rtl/a_pw_entry.sv
// Password entry front end: shifts four BCD keypad digits into a 16-bit word.
// Optional macro PW_KEY_SYNC_EN: synchronise a level key_valid and edge-detect it.
module a_pw_entry #(
  parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
  input logic        clk,
  input logic        reset,
  a_pw_entry_if.slave bus
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t         state_q;
  logic [15:0]    pw_q;
  logic [2:0]     cnt_q;
  logic           enough_q;
  logic           accept_q;
  logic           tmo_q;
  logic [TW-1:0]  timer_q;

  logic           key_stb;
  logic [3:0]     key_cd;

`ifdef PW_KEY_SYNC_EN
  // key_code rides a two-deep pipe so it lines up with the synchronised edge
  logic [2:0] kv_sync_q;
  logic [3:0] code_p0_q;
  logic [3:0] code_p1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kv_sync_q <= 3'b000;
      code_p0_q <= 4'h0;
      code_p1_q <= 4'h0;
    end else begin
      kv_sync_q <= {kv_sync_q[1:0], bus.key_valid};
      code_p0_q <= bus.key_code;
      code_p1_q <= code_p0_q;
    end
  end

  assign key_stb = kv_sync_q[1] & ~kv_sync_q[2];
  assign key_cd  = code_p1_q;
`else
  assign key_stb = bus.key_valid;
  assign key_cd  = bus.key_code;
`endif

  logic is_digit;
  logic is_bksp;
  logic is_clr;
  logic expire;

  assign is_digit = (key_cd <= 4'h9);
  assign is_bksp  = (key_cd == 4'hF);
  assign is_clr   = (key_cd == 4'hE);
  assign expire   = (state_q == COLLECT) && (timer_q == TIMER_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pw_q     <= 16'h0000;
      cnt_q    <= 3'd0;
      enough_q <= 1'b0;
      accept_q <= 1'b0;
      tmo_q    <= 1'b0;
      timer_q  <= '0;
    end else begin
      accept_q <= 1'b0;
      tmo_q    <= 1'b0;
      // Priority: lock_out > gen_rst > timer expiry > key
      if (bus.lock_out || bus.gen_rst) begin
        state_q  <= IDLE;
        pw_q     <= 16'h0000;
        cnt_q    <= 3'd0;
        enough_q <= 1'b0;
        timer_q  <= '0;
      end else if (expire) begin
        state_q  <= IDLE;
        pw_q     <= 16'h0000;
        cnt_q    <= 3'd0;
        enough_q <= 1'b0;
        timer_q  <= '0;
        tmo_q    <= 1'b1;
      end else if (key_stb && is_digit && (state_q != FULL)) begin
        pw_q     <= {pw_q[11:0], key_cd};
        cnt_q    <= cnt_q + 3'd1;
        accept_q <= 1'b1;
        timer_q  <= '0;
        state_q  <= (cnt_q == 3'd3) ? FULL : COLLECT;
        enough_q <= (cnt_q == 3'd3);
      end else if (key_stb && is_bksp && (state_q != IDLE)) begin
        pw_q     <= {4'h0, pw_q[15:4]};
        cnt_q    <= cnt_q - 3'd1;
        accept_q <= 1'b1;
        timer_q  <= '0;
        state_q  <= (cnt_q == 3'd1) ? IDLE : COLLECT;
        enough_q <= 1'b0;
      end else if (key_stb && is_clr) begin
        state_q  <= IDLE;
        pw_q     <= 16'h0000;
        cnt_q    <= 3'd0;
        enough_q <= 1'b0;
        timer_q  <= '0;
        accept_q <= (cnt_q != 3'd0);
      end else if (state_q == COLLECT) begin
        timer_q  <= timer_q + TW'(1);
      end else begin
        timer_q  <= '0;
      end
    end
  end

  assign bus.pw_16bit      = pw_q;
  assign bus.enough        = enough_q;
  assign bus.digit_count   = cnt_q;
  assign bus.key_accept    = accept_q;
  assign bus.entry_timeout = tmo_q;

endmodule

// File: tb/tb_a_pw_entry.sv
// Directed bench for a_pw_entry: per-key expectations queued on drive, checked on output.
module tb_a_pw_entry;
  localparam int TMO = 16;
`ifdef PW_KEY_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset;

  a_pw_entry_if bus();

  a_pw_entry #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int acc_pulses = 0;

  typedef struct packed {
    logic [15:0] pw;
    logic [2:0]  cnt;
    logic        en;
    logic        acc;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] m_pw = 16'h0;
  logic [2:0]  m_cnt = 3'd0;

  always @(negedge clk) if (bus.key_accept === 1'b1) acc_pulses++;

  initial begin
    #300000;
    $display("FAIL watchdog: observed no end of run, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_key(input logic [3:0] c, output logic acc);
    acc = 1'b0;
    if (c <= 4'h9) begin
      if (m_cnt < 3'd4) begin
        m_pw  = {m_pw[11:0], c};
        m_cnt = m_cnt + 3'd1;
        acc   = 1'b1;
      end
    end else if (c == 4'hF) begin
      if (m_cnt > 3'd0) begin
        m_pw  = {4'h0, m_pw[15:4]};
        m_cnt = m_cnt - 3'd1;
        acc   = 1'b1;
      end
    end else if (c == 4'hE) begin
      acc   = (m_cnt != 3'd0);
      m_pw  = 16'h0;
      m_cnt = 3'd0;
    end
  endtask

  task automatic press(input logic [3:0] c, input logic dropped, input int gap);
    exp_t e;
    logic acc;
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = c;
    if (dropped) acc = 1'b0;
    else model_key(c, acc);
    e = '{pw: m_pw, cnt: m_cnt, en: (m_cnt == 3'd4), acc: acc};
    sb_q.push_back(e);
    @(negedge clk);
    bus.key_valid = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    e = sb_q.pop_front();
    check($sformatf("key%0h_pw", c),  bus.pw_16bit,    e.pw);
    check($sformatf("key%0h_cnt", c), bus.digit_count, e.cnt);
    check($sformatf("key%0h_en", c),  bus.enough,      e.en);
    check($sformatf("key%0h_acc", c), bus.key_accept,  e.acc);
    repeat (gap) @(negedge clk);
  endtask

  task automatic model_clear();
    m_pw  = 16'h0;
    m_cnt = 3'd0;
  endtask

  initial begin
    int base;
    logic seen;
    reset         = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.gen_rst   = 1'b0;
    bus.lock_out  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pw",  bus.pw_16bit,      16'h0);
    check("rst_cnt", bus.digit_count,   3'd0);
    check("rst_en",  bus.enough,        1'b0);
    check("rst_acc", bus.key_accept,    1'b0);
    check("rst_tmo", bus.entry_timeout, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // 1: four digits fill the word
    base = acc_pulses;
    press(4'h1, 1'b0, 3);
    press(4'h2, 1'b0, 3);
    press(4'h3, 1'b0, 3);
    press(4'h4, 1'b0, 3);
    check("t1_pw",     bus.pw_16bit,       16'h1234);
    check("t1_cnt",    bus.digit_count,    3'd4);
    check("t1_en",     bus.enough,         1'b1);
    check("t1_pulses", acc_pulses - base,  4);

    // 2: backspace within an entry, then backspace on an empty entry
    press(4'hE, 1'b0, 3);
    press(4'h5, 1'b0, 3);
    press(4'h6, 1'b0, 3);
    press(4'hF, 1'b0, 3);
    press(4'h7, 1'b0, 3);
    check("t2_pw",  bus.pw_16bit,    16'h0057);
    check("t2_cnt", bus.digit_count, 3'd2);
    press(4'hE, 1'b0, 3);
    press(4'hF, 1'b0, 3);
    check("t2_idle_bs_pw", bus.pw_16bit, 16'h0);

    // 3: FULL ignores digits and reserved codes; gen_rst beats a same-cycle key
    press(4'h9, 1'b0, 3);
    press(4'h8, 1'b0, 3);
    press(4'h7, 1'b0, 3);
    press(4'h6, 1'b0, 3);
    check("t3_full_pw", bus.pw_16bit, 16'h9876);
    press(4'h0, 1'b0, 3);
    press(4'hB, 1'b0, 3);
    @(negedge clk);
    bus.gen_rst = 1'b1;
`ifndef PW_KEY_SYNC_EN
    bus.key_valid = 1'b1;
    bus.key_code  = 4'h3;
`endif
    model_clear();
    @(negedge clk);
    bus.gen_rst   = 1'b0;
    bus.key_valid = 1'b0;
    check("t3_grst_pw",  bus.pw_16bit,    16'h0);
    check("t3_grst_cnt", bus.digit_count, 3'd0);
    check("t3_grst_en",  bus.enough,      1'b0);
    check("t3_grst_acc", bus.key_accept,  1'b0);
    repeat (4) @(negedge clk);
    check("t3_grst_late_cnt", bus.digit_count, 3'd0);

`ifndef PW_KEY_SYNC_EN
    // 4a: a key landing on the expiry cycle is dropped
    press(4'h7, 1'b0, 0);
    repeat (14) @(negedge clk);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'h5;
    @(negedge clk);
    bus.key_valid = 1'b0;
    model_clear();
    check("t4a_tmo", bus.entry_timeout, 1'b1);
    check("t4a_pw",  bus.pw_16bit,      16'h0);
    check("t4a_acc", bus.key_accept,    1'b0);
    repeat (3) @(negedge clk);
`endif

    // 4: timeout exactly TMO cycles after the accepted key
    press(4'h8, 1'b0, 0);
    seen = 1'b0;
    for (int i = 1; i < TMO; i++) begin
      @(negedge clk);
      if (bus.entry_timeout === 1'b1) seen = 1'b1;
    end
    check("t4_tmo_early", seen, 1'b0);
    @(negedge clk);
    model_clear();
    check("t4_tmo",     bus.entry_timeout, 1'b1);
    check("t4_tmo_pw",  bus.pw_16bit,      16'h0);
    check("t4_tmo_cnt", bus.digit_count,   3'd0);
    @(negedge clk);
    check("t4_tmo_once", bus.entry_timeout, 1'b0);

    press(4'h1, 1'b0, 3);
    press(4'h2, 1'b0, 3);
    press(4'h3, 1'b0, 3);
    press(4'h4, 1'b0, 0);
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (bus.entry_timeout === 1'b1) seen = 1'b1;
    end
    check("t4_full_notmo", seen, 1'b0);
    check("t4_full_pw", bus.pw_16bit, 16'h1234);

    // 5: lockout clears and swallows keys
    press(4'hE, 1'b0, 3);
    press(4'h1, 1'b0, 3);
    press(4'h2, 1'b0, 3);
    @(negedge clk);
    bus.lock_out = 1'b1;
    model_clear();
    @(negedge clk);
    check("t5_lock_pw",  bus.pw_16bit,    16'h0);
    check("t5_lock_cnt", bus.digit_count, 3'd0);
    base = acc_pulses;
    press(4'h1, 1'b1, 3);
    press(4'h2, 1'b1, 3);
    press(4'h3, 1'b1, 3);
    press(4'h4, 1'b1, 3);
    check("t5_lock_pulses", acc_pulses - base, 0);
    @(negedge clk);
    bus.lock_out = 1'b0;
    @(negedge clk);
    press(4'h4, 1'b0, 3);
    check("t5_after_pw", bus.pw_16bit, 16'h0004);

    // 6: asynchronous reset mid-entry
    press(4'hE, 1'b0, 3);
    press(4'h1, 1'b0, 3);
    press(4'h2, 1'b0, 3);
    press(4'h3, 1'b0, 3);
    check("t6_pre_pw", bus.pw_16bit, 16'h0123);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("t6_arst_pw",  bus.pw_16bit,      16'h0);
    check("t6_arst_cnt", bus.digit_count,   3'd0);
    check("t6_arst_en",  bus.enough,        1'b0);
    check("t6_arst_acc", bus.key_accept,    1'b0);
    check("t6_arst_tmo", bus.entry_timeout, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    seen = 1'b0;
    repeat (2 * TMO) begin
      @(negedge clk);
      if (bus.entry_timeout === 1'b1) seen = 1'b1;
    end
    check("t6_no_tmo", seen, 1'b0);
    check("t6_cnt",    bus.digit_count, 3'd0);

`ifdef PW_KEY_SYNC_EN
    // 7: a held key produces a single digit, three edges after it rises
    base = acc_pulses;
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'h5;
    repeat (3) @(negedge clk);
    check("t7_acc", bus.key_accept, 1'b1);
    check("t7_pw",  bus.pw_16bit,   16'h0005);
    repeat (7) @(negedge clk);
    bus.key_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("t7_pulses", acc_pulses - base, 1);
    check("t7_cnt",    bus.digit_count,   3'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
